slot_supervisor: RTL



---
 rtl/slot_supervisor.sv | 79 +++++++
 1 files changed

// File: rtl/slot_supervisor.sv
// Per-slot watchdog and restart controller for the 4-slot barrel-threaded J1.
// Snoops the core I/O write bus and drives kill_slot_rq back into the core.
module slot_supervisor #(
    parameter int          WDT_W     = 16,
    parameter logic [15:0] KICK_ADDR = 16'h4000,
    parameter logic [15:0] KILL_ADDR = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_slot,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] dout,
    input  logic [3:0]  host_kill,
    input  logic [3:0]  host_park,
    input  logic [3:0]  host_clr,
    output logic [3:0]  kill_slot_rq,
    output logic [3:0]  wdt_armed,
    output logic [3:0]  wdt_fired,
    output logic [3:0]  parked
);

    logic [3:0] r_parked;
    logic       w_kick_wr;
    logic       w_kill_wr;

    assign w_kick_wr = io_wr && (io_addr == KICK_ADDR);
    assign w_kill_wr = io_wr && (io_addr == KILL_ADDR);
    assign parked    = r_parked;

    always_ff @(posedge clk) begin
        if (reset) r_parked <= 4'h0;
        else       r_parked <= host_park;
    end

    for (genvar s = 0; s < 4; s++) begin : g_slot
        logic [WDT_W-1:0] r_cnt;
        logic             r_fired;
        logic             r_kill;
        logic             w_own;
        logic             w_kick;
        logic             w_tick;
        logic             w_exp;
        logic             w_kill;

        assign w_own  = (io_slot == 2'(s));
        assign w_kick = w_kick_wr && w_own && !r_parked[s];
        // A kick on the slot's own visit reloads instead of decrementing.
        assign w_tick = w_own && (r_cnt != '0) && !w_kick && !r_parked[s];
        assign w_exp  = w_tick && (r_cnt == WDT_W'(1));
        assign w_kill = w_exp || (w_kill_wr && dout[s]) || host_kill[s];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_fired <= 1'b0;
                r_kill  <= 1'b0;
            end else begin
                r_kill <= w_kill || r_parked[s];
                if (w_kill || r_parked[s])
                    r_cnt <= '0;
                else if (w_kick)
                    r_cnt <= dout[WDT_W-1:0];
                else if (w_tick)
                    r_cnt <= r_cnt - 1'b1;
                // Expiry beats a same-cycle host clear.
                if (w_exp)
                    r_fired <= 1'b1;
                else if (host_clr[s])
                    r_fired <= 1'b0;
            end
        end

        assign wdt_armed[s]    = (r_cnt != '0);
        assign wdt_fired[s]    = r_fired;
        assign kill_slot_rq[s] = r_kill;
    end

endmodule
